// File: rtl/apb_arb_n.sv
// rtl/apb_arb_n.sv - APB-configured N-channel arbiter with IDLE/GRANT/REL handshake
// Optional feature macro: APB_ARB_GNT_CNT_EN (per-channel saturating grant counters at 0x40+4*ch)
module apb_arb_n #(
  parameter int NUM_CH   = 4,
  parameter int HOLD_RST = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              PSEL,
  input  logic              PENABLE,
  input  logic              PWRITE,
  input  logic [7:0]        PADDR,
  input  logic [7:0]        PWDATA,
  output logic [7:0]        PRDATA,
  output logic              PREADY,
  output logic              PSLVERR,
  input  logic [NUM_CH-1:0] req,
  output logic [NUM_CH-1:0] gnt
);

  localparam int IW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [7:0] NUM_CH8 = 8'(NUM_CH);

  typedef enum logic [1:0] {IDLE, GRANT, REL} state_t;

  state_t            state;
  logic              bypass;
  logic [NUM_CH-1:0] swreq;
  logic [2:0]        prio;
  logic [2:0]        mode;
  logic [7:0]        hold_max;
  logic [7:0]        hold_cnt;
  logic [IW-1:0]     rr_ptr;
  logic [IW-1:0]     gidx;

  logic [NUM_CH-1:0] ereq;
  logic [IW-1:0]     win;
  logic              found;
  logic [IW-1:0]     rr_idx;
  logic              access;
  logic              hit;
  logic              bad_wr;
  logic              wr_en;
  logic [7:0]        rd_mux;
  logic [7:0]        swreq_ext;
  logic              new_grant;

`ifdef APB_ARB_GNT_CNT_EN
  logic [7:0]        gcnt [NUM_CH];
`endif

  assign ereq      = bypass ? swreq : req;
  assign new_grant = (state == IDLE) && (|ereq);

  // Winner selection; only consumed in IDLE, so config written mid-grant takes effect at the next arbitration
  always_comb begin
    win    = '0;
    found  = 1'b0;
    rr_idx = '0;
    case (mode)
      3'd0: begin
        for (int i = 0; i < NUM_CH; i++) begin
          if (!found && ereq[i]) begin
            win   = IW'(i);
            found = 1'b1;
          end
        end
      end
      3'd1: begin
        for (int i = NUM_CH - 1; i >= 0; i--) begin
          if (!found && ereq[i]) begin
            win   = IW'(i);
            found = 1'b1;
          end
        end
      end
      3'd2: begin
        for (int i = 0; i < NUM_CH; i++) begin
          if (ereq[i] && (prio == 3'(i))) begin
            win   = IW'(i);
            found = 1'b1;
          end
        end
        for (int i = 0; i < NUM_CH; i++) begin
          if (!found && ereq[i]) begin
            win   = IW'(i);
            found = 1'b1;
          end
        end
      end
      default: begin
        for (int k = 0; k < NUM_CH; k++) begin
          rr_idx = IW'((int'(rr_ptr) + 1 + k) % NUM_CH);
          if (!found && ereq[rr_idx]) begin
            win   = rr_idx;
            found = 1'b1;
          end
        end
      end
    endcase
  end

  // APB decode: read mux, error detection and write qualification
  always_comb begin
    access    = PSEL & PENABLE;
    PREADY    = 1'b1;
    hit       = 1'b1;
    bad_wr    = 1'b0;
    rd_mux    = 8'h00;
    swreq_ext = 8'h00;
    swreq_ext[NUM_CH-1:0] = swreq;
    case (PADDR)
      8'h10: rd_mux = {7'b0, bypass};
      8'h14: rd_mux = swreq_ext;
      8'h18: begin
        rd_mux = {5'b0, prio};
        bad_wr = PWRITE && (PWDATA >= NUM_CH8);
      end
      8'h1C: rd_mux = {5'b0, mode};
      8'h20: begin
        rd_mux = swreq_ext & 8'h00;
        rd_mux[NUM_CH-1:0] = gnt;
        bad_wr = PWRITE;
      end
      8'h24: rd_mux = hold_max;
      default: begin
        hit = 1'b0;
`ifdef APB_ARB_GNT_CNT_EN
        for (int ch = 0; ch < NUM_CH; ch++) begin
          if (PADDR == 8'(64 + 4 * ch)) begin
            hit    = 1'b1;
            rd_mux = gcnt[ch];
          end
        end
`endif
      end
    endcase
    PSLVERR = access & (~hit | bad_wr);
    PRDATA  = access ? rd_mux : 8'h00;
    wr_en   = access & PWRITE & ~PSLVERR;
  end

  // Configuration registers; reset takes priority over a coincident write
  always_ff @(posedge clk) begin
    if (rst) begin
      bypass   <= 1'b0;
      swreq    <= '0;
      prio     <= 3'd0;
      mode     <= 3'b100;
      hold_max <= 8'(HOLD_RST);
    end else if (wr_en) begin
      case (PADDR)
        8'h10:   bypass   <= PWDATA[0];
        8'h14:   swreq    <= PWDATA[NUM_CH-1:0];
        8'h18:   prio     <= PWDATA[2:0];
        8'h1C:   mode     <= PWDATA[2:0];
        8'h24:   hold_max <= PWDATA;
        default: ;
      endcase
    end
  end

  // Arbitration FSM with registered one-hot grant and hold counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      gnt      <= '0;
      gidx     <= '0;
      rr_ptr   <= IW'(NUM_CH - 1);
      hold_cnt <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          if (|ereq) begin
            state    <= GRANT;
            gnt      <= {{(NUM_CH-1){1'b0}}, 1'b1} << win;
            gidx     <= win;
            rr_ptr   <= win;
            hold_cnt <= 8'd1;
          end
        end
        GRANT: begin
          // >= so that lowering HOLD_MAX below the running count still releases
          if (!ereq[gidx] || ((hold_max != 8'd0) && (hold_cnt >= hold_max))) begin
            state    <= REL;
            gnt      <= '0;
            hold_cnt <= 8'd0;
          end else if (hold_cnt != 8'hFF) begin
            hold_cnt <= hold_cnt + 8'd1;
          end
        end
        REL: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          gnt   <= '0;
        end
      endcase
    end
  end

`ifdef APB_ARB_GNT_CNT_EN
  // Saturating per-channel grant counters; a write to a counter clears it
  always_ff @(posedge clk) begin
    for (int ch = 0; ch < NUM_CH; ch++) begin
      if (rst) begin
        gcnt[ch] <= 8'd0;
      end else if (wr_en && (PADDR == 8'(64 + 4 * ch))) begin
        gcnt[ch] <= 8'd0;
      end else if (new_grant && (win == IW'(ch)) && (gcnt[ch] != 8'hFF)) begin
        gcnt[ch] <= gcnt[ch] + 8'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_apb_arb_n.sv
// tb/tb_apb_arb_n.sv - directed table-driven bench for apb_arb_n
module tb_apb_arb_n;

  logic       clk;
  logic       rst;
  logic       PSEL;
  logic       PENABLE;
  logic       PWRITE;
  logic [7:0] PADDR;
  logic [7:0] PWDATA;
  logic [7:0] PRDATA;
  logic       PREADY;
  logic       PSLVERR;
  logic [3:0] req;
  logic [3:0] gnt;

  int checks = 0;
  int errors = 0;

  apb_arb_n #(.NUM_CH(4), .HOLD_RST(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .PSEL    (PSEL),
    .PENABLE (PENABLE),
    .PWRITE  (PWRITE),
    .PADDR   (PADDR),
    .PWDATA  (PWDATA),
    .PRDATA  (PRDATA),
    .PREADY  (PREADY),
    .PSLVERR (PSLVERR),
    .req     (req),
    .gnt     (gnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       wr;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp_rd;
    logic       exp_err;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset;
    rst     = 1'b1;
    PSEL    = 1'b0;
    PENABLE = 1'b0;
    PWRITE  = 1'b0;
    PADDR   = 8'h00;
    PWDATA  = 8'h00;
    req     = 4'b0000;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic apb(input logic wr, input logic [7:0] a, input logic [7:0] d,
                     output logic [7:0] rd, output logic er);
    @(posedge clk);
    #1;
    PSEL    = 1'b1;
    PENABLE = 1'b0;
    PWRITE  = wr;
    PADDR   = a;
    PWDATA  = d;
    @(posedge clk);
    #1 PENABLE = 1'b1;
    @(negedge clk);
    rd = PRDATA;
    er = PSLVERR;
    @(posedge clk);
    #1;
    PSEL    = 1'b0;
    PENABLE = 1'b0;
    PWRITE  = 1'b0;
  endtask

  task automatic gnt_sample(input string name, input logic [3:0] exp);
    @(negedge clk);
    chk(name, gnt, exp);
    chk("onehot0", $onehot0(gnt), 1);
  endtask

  vec_t       tbl [22];
  logic [7:0] rd;
  logic       er;
  logic [3:0] rr_exp [17];
  logic [3:0] m0_exp [4];

  initial begin
    tbl[0]  = '{1'b0, 8'h1C, 8'h00, 8'h04, 1'b0};
    tbl[1]  = '{1'b0, 8'h24, 8'h00, 8'h08, 1'b0};
    tbl[2]  = '{1'b0, 8'h30, 8'h00, 8'h00, 1'b1};
    tbl[3]  = '{1'b0, 8'h10, 8'h00, 8'h00, 1'b0};
    tbl[4]  = '{1'b0, 8'h18, 8'h00, 8'h00, 1'b0};
    tbl[5]  = '{1'b0, 8'h20, 8'h00, 8'h00, 1'b0};
    tbl[6]  = '{1'b1, 8'h20, 8'hFF, 8'h00, 1'b1};
    tbl[7]  = '{1'b1, 8'h18, 8'h04, 8'h00, 1'b1};
    tbl[8]  = '{1'b0, 8'h18, 8'h00, 8'h00, 1'b0};
    tbl[9]  = '{1'b1, 8'h18, 8'h02, 8'h00, 1'b0};
    tbl[10] = '{1'b0, 8'h18, 8'h00, 8'h02, 1'b0};
    tbl[11] = '{1'b1, 8'h1C, 8'hFD, 8'h00, 1'b0};
    tbl[12] = '{1'b0, 8'h1C, 8'h00, 8'h05, 1'b0};
    tbl[13] = '{1'b1, 8'h14, 8'hFA, 8'h00, 1'b0};
    tbl[14] = '{1'b0, 8'h14, 8'h00, 8'h0A, 1'b0};
    tbl[15] = '{1'b1, 8'h14, 8'h00, 8'h00, 1'b0};
    tbl[16] = '{1'b1, 8'h10, 8'hFE, 8'h00, 1'b0};
    tbl[17] = '{1'b0, 8'h10, 8'h00, 8'h00, 1'b0};
    tbl[18] = '{1'b1, 8'h24, 8'h00, 8'h00, 1'b0};
    tbl[19] = '{1'b0, 8'h24, 8'h00, 8'h00, 1'b0};
    tbl[20] = '{1'b0, 8'h5C, 8'h00, 8'h00, 1'b1};
    tbl[21] = '{1'b1, 8'h7F, 8'h55, 8'h00, 1'b1};

    rr_exp = '{4'b0001, 4'b0001, 4'b0000, 4'b0000,
               4'b0010, 4'b0010, 4'b0000, 4'b0000,
               4'b0100, 4'b0100, 4'b0000, 4'b0000,
               4'b1000, 4'b1000, 4'b0000, 4'b0000,
               4'b0001};
    m0_exp = '{4'b0010, 4'b0000, 4'b0000, 4'b1000};

    // Reset state and register map
    do_reset();
    @(negedge clk);
    chk("reset_gnt", gnt, 4'b0000);
    chk("pready", PREADY, 1'b1);
    for (int i = 0; i < 22; i++) begin
      apb(tbl[i].wr, tbl[i].addr, tbl[i].wdata, rd, er);
      chk($sformatf("tbl%0d_err", i), er, tbl[i].exp_err);
      if (!tbl[i].wr) chk($sformatf("tbl%0d_rd", i), rd, tbl[i].exp_rd);
    end

    // MODE 0 lowest index, release on request drop
    do_reset();
    apb(1'b1, 8'h1C, 8'h00, rd, er);
    req = 4'b1010;
    @(posedge clk);
    gnt_sample("m0_first", 4'b0010);
    @(posedge clk);
    #1 req = 4'b1000;
    for (int i = 0; i < 4; i++) gnt_sample($sformatf("m0_seq%0d", i), m0_exp[i]);

    // MODE 1 highest index with unlimited hold
    do_reset();
    apb(1'b1, 8'h1C, 8'h01, rd, er);
    apb(1'b1, 8'h24, 8'h00, rd, er);
    req = 4'b0110;
    @(posedge clk);
    for (int i = 0; i < 12; i++) gnt_sample($sformatf("m1_hold%0d", i), 4'b0100);

    // Round robin with HOLD_MAX=2
    do_reset();
    apb(1'b1, 8'h24, 8'h02, rd, er);
    req = 4'b1111;
    @(posedge clk);
    for (int i = 0; i < 17; i++) gnt_sample($sformatf("rr%0d", i), rr_exp[i]);

    // MODE 2 priority channel and illegal PRIO write
    do_reset();
    apb(1'b1, 8'h1C, 8'h02, rd, er);
    apb(1'b1, 8'h18, 8'h03, rd, er);
    req = 4'b1001;
    @(posedge clk);
    gnt_sample("m2_prio", 4'b1000);
    apb(1'b1, 8'h18, 8'h05, rd, er);
    chk("prio5_err", er, 1'b1);
    apb(1'b0, 8'h18, 8'h00, rd, er);
    chk("prio_kept", rd, 8'h03);

    // BYPASS with SWREQ, then reset mid-grant coinciding with a MODE write
    do_reset();
    apb(1'b1, 8'h14, 8'h04, rd, er);
    apb(1'b1, 8'h10, 8'h01, rd, er);
    req = 4'b0001;
    @(posedge clk);
    gnt_sample("bypass_gnt", 4'b0100);
    @(posedge clk);
    #1;
    rst     = 1'b1;
    PSEL    = 1'b1;
    PENABLE = 1'b1;
    PWRITE  = 1'b1;
    PADDR   = 8'h1C;
    PWDATA  = 8'h01;
    gnt_sample("rst_gnt_ongoing", 4'b0100);
    gnt_sample("rst_gnt_cleared", 4'b0000);
    PSEL    = 1'b0;
    PENABLE = 1'b0;
    PWRITE  = 1'b0;
    req     = 4'b0000;
    #1 rst  = 1'b0;
    apb(1'b0, 8'h1C, 8'h00, rd, er);
    chk("rst_mode", rd, 8'h04);

`ifdef APB_ARB_GNT_CNT_EN
    // Grant counter saturation and clear
    do_reset();
    apb(1'b1, 8'h1C, 8'h00, rd, er);
    apb(1'b1, 8'h24, 8'h01, rd, er);
    req = 4'b0001;
    repeat (910) @(posedge clk);
    #1 req = 4'b0000;
    apb(1'b0, 8'h40, 8'h00, rd, er);
    chk("cnt_sat", rd, 8'hFF);
    chk("cnt_err", er, 1'b0);
    apb(1'b1, 8'h40, 8'h00, rd, er);
    apb(1'b0, 8'h40, 8'h00, rd, er);
    chk("cnt_clr", rd, 8'h00);
`else
    apb(1'b0, 8'h40, 8'h00, rd, er);
    chk("cnt_absent_err", er, 1'b1);
    chk("cnt_absent_rd", rd, 8'h00);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/apb_arb_n.md
APB_ARB_N -- requirements
Module: apb_arb_n

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, number of requesters, legal 2..8.
REQ-002 SHALL have parameter HOLD_RST, default 8, reset value of HOLD_MAX register.
REQ-003 SHALL have port clk  input  1  sole clock, all logic on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset; one clock, reset synchronous active-high.
REQ-005 SHALL have ports PSEL, PENABLE, PWRITE  input  1 each  APB control.
REQ-006 SHALL have ports PADDR  input  8 and PWDATA  input  8  APB address/write data.
REQ-007 SHALL have ports PRDATA  output  8, PREADY  output  1, PSLVERR  output  1  APB response.
REQ-008 SHALL have port req  input  NUM_CH  hardware requests.
REQ-009 SHALL have port gnt  output  NUM_CH  one-hot-or-zero registered grants.

Function
REQ-010 SHALL drive PREADY=1 always (zero wait state).
REQ-011 SHALL commit a write on the edge where PSEL&PENABLE&PWRITE=1; PRDATA is combinational from registers in that access phase, 0 otherwise.
REQ-012 SHALL map: 0x10 CTRL[0]=BYPASS; 0x14 SWREQ[NUM_CH-1:0]; 0x18 PRIO[2:0] top channel; 0x1C MODE[2:0]; 0x20 STATUS RO = gnt; 0x24 HOLD_MAX[7:0]; unused bits read 0, writes ignored.
REQ-013 SHALL assert PSLVERR in an access phase to any unmapped address, to PRIO with value >= NUM_CH, or to write 0x20; such writes change nothing.
REQ-014 SHALL arbitrate on effective request ereq = BYPASS ? SWREQ : req.
REQ-015 SHALL implement FSM IDLE/GRANT/REL: IDLE->GRANT when ereq!=0; GRANT->REL when ereq[granted]=0 or hold expiry; REL->IDLE unconditionally.
REQ-016 SHALL assert gnt one cycle after the edge where IDLE sees ereq!=0 (latency 1), hold it through GRANT, drive 0 in IDLE and REL.
REQ-017 SHALL select in MODE 0 lowest index; MODE 1 highest index; MODE 2 channel PRIO first, then others ascending; MODE 4 round robin; MODE 3,5,6,7 behave as MODE 4.
REQ-018 SHALL, in round robin, start search at (last granted+1) mod NUM_CH; pointer updates only on new grant.
REQ-019 SHALL count GRANT cycles; when count == HOLD_MAX and HOLD_MAX != 0 force GRANT->REL even if request stays high; HOLD_MAX=0 means unlimited.
REQ-020 SHALL apply MODE, PRIO, BYPASS, SWREQ changes written during GRANT only at the next IDLE arbitration; a current grant is kept while its ereq bit stays high.
REQ-021 SHALL never assert more than one gnt bit in any cycle.

Reset
REQ-022 SHALL on rst: gnt=0, FSM=IDLE, RR pointer=NUM_CH-1 (first search from ch0), hold count=0, BYPASS=0, SWREQ=0, PRIO=0, MODE=3'b100, HOLD_MAX=HOLD_RST, counters 0.
REQ-023 SHALL, on rst asserted mid-grant, drive gnt=0 the following cycle; rst overrides simultaneous APB writes.

Configuration
REQ-024 SHALL, with macro APB_ARB_GNT_CNT_EN defined, add per-channel 8-bit saturating grant counters (increment per new grant) readable at 0x40+4*ch, cleared by any write to that address.
REQ-025 SHALL, without APB_ARB_GNT_CNT_EN, omit counters; 0x40..0x5C are unmapped (PSLVERR=1, PRDATA=0).

Verification
REQ-026 SHALL cover: reset then read 0x1C -> PRDATA=0x04; read 0x24 -> 0x08; read 0x30 -> PSLVERR=1.
REQ-027 SHALL cover: MODE=0, req=4'b1010 held -> gnt=4'b0010 next cycle; drop req[1] -> gnt 0 for REL, then gnt=4'b1000.
REQ-028 SHALL cover: MODE=4, req=4'b1111 held, HOLD_MAX=2 -> gnt sequence 0001,0001,0,0,0010,0010,0,0,0100 ...; each grant exactly 2 cycles.
REQ-029 SHALL cover: MODE=2, PRIO=3, req=4'b1001 -> gnt=4'b1000; write PRIO=5 -> PSLVERR=1, PRIO stays 3.
REQ-030 SHALL cover: BYPASS=1, SWREQ=4'b0100, req=4'b0001 -> gnt=4'b0100; rst during grant -> gnt=0 next cycle, MODE reads 0x04.
REQ-031 SHALL cover (APB_ARB_GNT_CNT_EN): 300 grants to ch0 -> read 0x40 = 0xFF; write 0x40 -> reads 0x00.
